// File: rtl/bus_dma_arbiter_if.sv
// bus_dma_arbiter_if: byte-wide request/response bus shared by the CPU side, main bus and high page.
// Signals: addr (AW bits), enable, write, wdata[7:0] driven by master; rdata[7:0] returned by slave.
// master drives the request, slave returns read data.
interface bus_dma_arbiter_if #(parameter int AW = 16);
    logic [AW-1:0] addr;
    logic          enable;
    logic          write;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    modport master (output addr, enable, write, wdata, input rdata);
    modport slave  (input addr, enable, write, wdata, output rdata);
endinterface

// File: rtl/bus_dma_arbiter.sv
// bus_dma_arbiter: CPU / OAM-DMA owner of the main bus, with the DMA source register at DMA_REG_ADDR.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   t_cycle    CPU T-cycle phase 0..3, an M-cycle ends at 3
//   cpu        slave side facing the CPU pins (AW=16)
//   bus        master side to the main bus 0000-FEFF (AW=16)
//   hi         master side to the high page FF00-FFFF (AW=8, offset only)
//   dma_active high while the DMA engine owns the main bus
// Optional feature: BUS_DMA_RESTART_EN lets a source write during a copy restart it.
module bus_dma_arbiter #(
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] DMA_DEST     = 16'hFE00,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        t_cycle,
    bus_dma_arbiter_if.slave  cpu,
    bus_dma_arbiter_if.master bus,
    bus_dma_arbiter_if.master hi,
    output logic              dma_active
);
    typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;
    localparam logic [7:0] LAST = 8'(DMA_LEN - 1);
    state_t     state, state_nxt;
    logic [7:0] src_reg, src_act, src_eff, index, latch;
    logic       hold, m_end, hi_sel, reg_hit, reg_wr, restart, cpu_main;
    assign m_end   = t_cycle == 2'd3;
    assign reg_hit = cpu.addr == DMA_REG_ADDR;
    assign hi_sel  = cpu.addr[15:8] == 8'hFF;
    assign reg_wr  = m_end && cpu.enable && cpu.write && reg_hit;
    // Echo RAM E000-FDFF mirrors C000-DDFF.
    assign src_eff = src_reg >= 8'hE0 ? src_reg - 8'h20 : src_reg;
`ifdef BUS_DMA_RESTART_EN
    assign restart = reg_wr && state == ACTIVE;
`else
    assign restart = 1'b0;
`endif
    // hold keeps the CPU locked out during the delay M-cycle of a restart.
    assign dma_active = state == ACTIVE || hold;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (restart)
            state_nxt = START;
        else if (m_end) begin
            if (state == IDLE && reg_wr)
                state_nxt = START;
            else if (state == START)
                state_nxt = ACTIVE;
            else if (state == ACTIVE && index == LAST)
                state_nxt = IDLE;
        end
    end
    // The source page is frozen at ACTIVE entry so plain register writes cannot disturb a copy.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            src_reg <= 8'h00;
            src_act <= 8'h00;
            index   <= 8'h00;
            latch   <= 8'h00;
            hold    <= 1'b0;
        end else begin
            if (reg_wr)
                src_reg <= cpu.wdata;
            if (state == ACTIVE && t_cycle == 2'd1)
                latch <= bus.rdata;
            if (restart) begin
                index <= 8'h00;
                hold  <= 1'b1;
            end else if (m_end && state == START) begin
                index   <= 8'h00;
                src_act <= src_eff;
                hold    <= 1'b0;
            end else if (m_end && state == ACTIVE)
                index <= index + 8'd1;
        end
    // reset_n gates the CPU path so every enable is low while reset is held.
    assign cpu_main = reset_n && cpu.enable && !hi_sel && !dma_active;
    always_comb begin
        bus.addr   = cpu.addr;
        bus.enable = cpu_main;
        bus.write  = cpu_main && cpu.write;
        bus.wdata  = cpu.wdata;
        if (state == ACTIVE) begin
            bus.addr   = t_cycle[1] ? {DMA_DEST[15:8], DMA_DEST[7:0] + index} : {src_act, index};
            bus.enable = 1'b1;
            bus.write  = t_cycle[1];
            bus.wdata  = latch;
        end
    end
    assign hi.addr   = cpu.addr[7:0];
    assign hi.enable = reset_n && cpu.enable && hi_sel && !reg_hit;
    assign hi.write  = hi.enable && cpu.write;
    assign hi.wdata  = cpu.wdata;
    assign cpu.rdata = reg_hit ? src_reg : hi_sel ? hi.rdata : dma_active ? 8'hFF : bus.rdata;
endmodule

// File: tb/tb_bus_dma_arbiter.sv
// tb_bus_dma_arbiter: self-checking bench for bus_dma_arbiter against an M-cycle-count model.
module tb_bus_dma_arbiter;
    localparam int DMA_LEN = 160;
    typedef struct {
        logic [15:0] addr;
        logic        en;
        logic        we;
        logic [7:0]  wd;
        logic        e_bus;
        logic        e_hi;
        logic [7:0]  e_rd;
    } vec_t;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] tc = 2'd0;
    logic       dma_active;
    int         total = 0, bad = 0, nw = 0;
    logic [7:0] m_src = 8'h00, m_hi = 8'h00;
    int         m_mc = -1;
    logic       m_hold = 1'b0;
    vec_t       vt[8];
    bus_dma_arbiter_if #(.AW(16)) cpu_if();
    bus_dma_arbiter_if #(.AW(16)) bus_if();
    bus_dma_arbiter_if #(.AW(8))  hi_if();
    always #5 clk = ~clk;
    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h3C;
    endfunction
    assign bus_if.rdata = memf(bus_if.addr);
    assign hi_if.rdata  = hi_if.addr ^ 8'hA5;
    bus_dma_arbiter #(.DMA_LEN(DMA_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .t_cycle(tc),
        .cpu(cpu_if), .bus(bus_if), .hi(hi_if), .dma_active(dma_active)
    );
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endtask
    task automatic set(input logic [15:0] a, input logic en, input logic we, input logic [7:0] wd);
        cpu_if.addr = a; cpu_if.enable = en; cpu_if.write = we; cpu_if.wdata = wd;
    endtask
    // One clock: check outputs against the model, take the edge, advance the model and the phase.
    task automatic step();
        logic hi_s, reg_s, xfer, act, be, wr;
        int k;
        logic [15:0] sa;
        #1;
        hi_s = cpu_if.addr[15:8] == 8'hFF;
        reg_s = cpu_if.addr == 16'hFF46;
        xfer = m_mc >= 1;
        act = xfer || m_hold;
        k = m_mc - 1;
        sa = {m_hi, 8'(k)};
        chk("dma_active", dma_active, act);
        if (xfer) begin
            chk("dma_bus_en", bus_if.enable, 1);
            chk("dma_bus_wr", bus_if.write, tc[1]);
            chk("dma_bus_addr", bus_if.addr, tc[1] ? 16'hFE00 + k : sa);
            if (tc[1]) chk("dma_bus_wdata", bus_if.wdata, memf(sa));
        end else begin
            be = !act && cpu_if.enable && !hi_s;
            chk("cpu_bus_en", bus_if.enable, be);
            chk("cpu_bus_wr", bus_if.write, be && cpu_if.write);
            if (be) chk("cpu_bus_addr", bus_if.addr, cpu_if.addr);
            if (be && cpu_if.write) chk("cpu_bus_wdata", bus_if.wdata, cpu_if.wdata);
        end
        chk("hi_en", hi_if.enable, cpu_if.enable && hi_s && !reg_s);
        chk("hi_wr", hi_if.write, cpu_if.enable && hi_s && !reg_s && cpu_if.write);
        if (cpu_if.enable && hi_s && !reg_s) chk("hi_addr", hi_if.addr, cpu_if.addr[7:0]);
        if (cpu_if.enable)
            chk("cpu_rdata", cpu_if.rdata, reg_s ? m_src : hi_s ? cpu_if.addr[7:0] ^ 8'hA5 : act ? 8'hFF : memf(cpu_if.addr));
        if (tc == 2'd3 && dma_active && bus_if.enable && bus_if.write) nw++;
        @(posedge clk);
        wr = cpu_if.enable && cpu_if.write && reg_s;
        if (tc == 2'd3) begin
`ifdef BUS_DMA_RESTART_EN
            if (wr && m_mc >= 1) begin
                m_src = cpu_if.wdata; m_mc = 0; m_hold = 1'b1;
            end else
`endif
            begin
                if (m_mc == 0) begin
                    m_mc = 1; m_hold = 1'b0;
                    m_hi = m_src >= 8'hE0 ? m_src - 8'h20 : m_src;
                end else if (m_mc >= 1)
                    m_mc = m_mc == DMA_LEN ? -1 : m_mc + 1;
                else if (wr)
                    m_mc = 0;
                if (wr) m_src = cpu_if.wdata;
            end
        end
        @(negedge clk);
        tc = tc + 2'd1;
    endtask
    task automatic begin_m(input logic [15:0] a, input logic en, input logic we, input logic [7:0] wd);
        set(16'h0000, 0, 0, 8'h00);
        while (tc != 2'd0) step();
        set(a, en, we, wd);
        #1;
    endtask
    task automatic mcyc(input logic [15:0] a, input logic en, input logic we, input logic [7:0] wd);
        begin_m(a, en, we, wd);
        repeat (4) step();
    endtask
    task automatic do_reset();
        #2 reset_n = 1'b0;
        set(16'h0150, 1, 1, 8'h11);
        #1 chk("rst_active", dma_active, 0);
        chk("rst_bus_en", bus_if.enable, 0);
        chk("rst_bus_wr", bus_if.write, 0);
        set(16'hFF80, 1, 1, 8'h22);
        #1 chk("rst_hi_en", hi_if.enable, 0);
        set(16'hFF46, 1, 0, 8'h00);
        #1 chk("rst_src", cpu_if.rdata, 8'h00);
        @(negedge clk);
        set(16'h0000, 0, 0, 8'h00);
        reset_n = 1'b1;
        tc = 2'd0;
        m_src = 8'h00; m_hi = 8'h00; m_mc = -1; m_hold = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < 300 && (dma_active || m_mc != -1); i++) mcyc(16'h0000, 0, 0, 8'h00);
        chk("drain", dma_active, 0);
    endtask
    task automatic run_full(input logic [7:0] src, input string nm);
        int n = 0;
        drain();
        nw = 0;
        mcyc(16'hFF46, 1, 1, src);
        chk({nm, "_start_gap"}, dma_active, 0);
        for (int i = 1; i <= 300; i++) begin
            mcyc(16'h0000, 0, 0, 8'h00);
            if (i == 1) chk({nm, "_on"}, dma_active, 1);
            if (!dma_active) begin
                n = i;
                break;
            end
        end
        chk({nm, "_mcycles"}, n, 161);
        chk({nm, "_writes"}, nw, DMA_LEN);
    endtask
    initial begin
        vt[0] = '{16'h0150, 1, 0, 8'h00, 1, 0, 8'h6D};
        vt[1] = '{16'hFF80, 1, 0, 8'h00, 0, 1, 8'h25};
        vt[2] = '{16'hFF46, 1, 0, 8'h00, 0, 0, 8'h00};
        vt[3] = '{16'h8000, 1, 1, 8'h77, 1, 0, 8'h00};
        vt[4] = '{16'hFF85, 1, 1, 8'h5A, 0, 1, 8'h00};
        vt[5] = '{16'hFEA0, 1, 0, 8'h00, 1, 0, 8'h62};
        vt[6] = '{16'h0000, 0, 0, 8'h00, 0, 0, 8'h00};
        vt[7] = '{16'hFFFF, 1, 0, 8'h00, 0, 1, 8'h5A};
        set(16'h0000, 0, 0, 8'h00);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set(vt[i].addr, vt[i].en, vt[i].we, vt[i].wd);
            #1;
            chk("vec_bus_en", bus_if.enable, vt[i].e_bus);
            chk("vec_hi_en", hi_if.enable, vt[i].e_hi);
            if (vt[i].e_bus) chk("vec_bus_addr", bus_if.addr, vt[i].addr);
            if (vt[i].en && !vt[i].we) chk("vec_rdata", cpu_if.rdata, vt[i].e_rd);
            step();
        end
        run_full(8'hC1, "c1");
        mcyc(16'hFF46, 1, 1, 8'hC1);
        repeat (4) mcyc(16'h0000, 0, 0, 8'h00);
        begin_m(16'hC000, 1, 0, 8'h00);
        chk("act_read_ff", cpu_if.rdata, 8'hFF);
        chk("act_no_cpu_cycle", bus_if.addr == 16'hC000, 0);
        repeat (4) step();
        begin_m(16'hFF85, 1, 1, 8'h5A);
        chk("act_hi_wr", hi_if.write, 1);
        chk("act_hi_addr", hi_if.addr, 8'h85);
        chk("act_hi_wdata", hi_if.wdata, 8'h5A);
        repeat (4) step();
        drain();
        mcyc(16'hFF46, 1, 1, 8'hF2);
        mcyc(16'h0000, 0, 0, 8'h00);
        begin_m(16'h0000, 0, 0, 8'h00);
        chk("mirror_first", bus_if.addr, 16'hD200);
        repeat (4) step();
        drain();
        mcyc(16'hFF46, 1, 1, 8'hC1);
        repeat (41) mcyc(16'h0000, 0, 0, 8'h00);
        begin_m(16'h0000, 0, 0, 8'h00);
        chk("rst40_addr", bus_if.addr, 16'hC128);
        step();
        step();
        nw = 0;
        do_reset();
        repeat (8) mcyc(16'h0000, 0, 0, 8'h00);
        chk("rst40_no_writes", nw, 0);
        run_full(8'hC1, "fresh");
        mcyc(16'hFF46, 1, 1, 8'hC1);
        repeat (10) mcyc(16'h0000, 0, 0, 8'h00);
        mcyc(16'hFF46, 1, 1, 8'hD0);
`ifdef BUS_DMA_RESTART_EN
        begin_m(16'h0000, 0, 0, 8'h00);
        chk("restart_hold_active", dma_active, 1);
        chk("restart_hold_bus", bus_if.enable, 0);
        repeat (4) step();
        begin_m(16'h0000, 0, 0, 8'h00);
        chk("restart_addr", bus_if.addr, 16'hD000);
        repeat (4) step();
`else
        begin_m(16'h0000, 0, 0, 8'h00);
        chk("norestart_addr", bus_if.addr, 16'hC10A);
        repeat (4) step();
`endif
        begin_m(16'hFF46, 1, 0, 8'h00);
        chk("src_readback", cpu_if.rdata, 8'hD0);
        repeat (4) step();
        drain();
        for (int i = 0; i < 6000; i++) begin
            int r;
            logic [15:0] a;
            r = $urandom_range(0, 99);
            a = 16'($urandom);
            if (r < 4) a = 16'hFF46;
            else if (r < 30) a[15:8] = 8'hFF;
            else if (r < 55) a[15:8] = 8'hC0 | 8'($urandom_range(0, 31));
            set(a, 1'($urandom), 1'($urandom), 8'($urandom));
            step();
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
